// File: rtl/nano_loader.sv
// nano_loader: loads a length-prefixed byte stream into the nano core's 256x8
// instruction memory, runs the core, and detects a self-branch halt.
// Latency: a byte accepted in cycle t is written in t+1. Backpressure: in_ready is
// registered from state only; LOAD is never throttled; in_ready=0 while RUN.
// Optional checksum byte after the program when NANO_LOADER_CKSUM_EN is defined.
module nano_loader #(
  parameter int HALT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        prog_we,
  output logic [7:0]  prog_addr,
  output logic [7:0]  prog_data,
  output logic        core_reset,
  input  logic [7:0]  core_pc,
  output logic        running,
  output logic        halted,
  output logic        error,
  output logic [15:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_HALT
`ifdef NANO_LOADER_CKSUM_EN
    , S_CHECK
`endif
  } state_t;

  localparam logic [8:0] HALT_LIM = 9'(HALT_CYCLES);

  state_t     state;
  logic [7:0] len;
  logic [7:0] wr_addr;
  logic [7:0] hold;     // length of the current run of identical core_pc samples
  logic [7:0] pc_prev;
  logic       accept;
  logic [8:0] run_len;

`ifdef NANO_LOADER_CKSUM_EN
  logic [7:0] sum;
  logic [7:0] cksum_total;
  assign cksum_total = sum + in_data;
`endif

  assign accept = in_valid & in_ready;

  // Run length including this cycle's sample; hold==0 marks the first sample of a run.
  always_comb begin
    run_len = 9'd1;
    if (hold != 8'd0 && core_pc == pc_prev) begin
      run_len = {1'b0, hold} + 9'd1;
    end
  end

  // Controller FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      in_ready    <= 1'b0;
      prog_we     <= 1'b0;
      prog_addr   <= 8'h00;
      prog_data   <= 8'h00;
      core_reset  <= 1'b1;
      running     <= 1'b0;
      halted      <= 1'b0;
      error       <= 1'b0;
      cycle_count <= 16'h0000;
      len         <= 8'h00;
      wr_addr     <= 8'h00;
      hold        <= 8'h00;
      pc_prev     <= 8'h00;
`ifdef NANO_LOADER_CKSUM_EN
      sum         <= 8'h00;
`endif
    end else begin
      prog_we <= 1'b0;
      if (abort) begin
        state      <= S_IDLE;
        in_ready   <= 1'b1;
        core_reset <= 1'b1;
        running    <= 1'b0;
        halted     <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_HALT: begin
            in_ready <= 1'b1;
            if (accept) begin
              halted <= 1'b0;
              if (in_data == 8'h00) begin
                error <= 1'b1;
                state <= S_IDLE;
              end else begin
                len         <= in_data;
                error       <= 1'b0;
                cycle_count <= 16'h0000;
                wr_addr     <= 8'h01;
                state       <= S_LOAD;
`ifdef NANO_LOADER_CKSUM_EN
                sum         <= 8'h00;
`endif
              end
            end
          end
          S_LOAD: begin
            if (accept) begin
              prog_we   <= 1'b1;
              prog_addr <= wr_addr;
              prog_data <= in_data;
              wr_addr   <= wr_addr + 8'd1;
`ifdef NANO_LOADER_CKSUM_EN
              sum       <= sum + in_data;
              if (wr_addr == len) begin
                state <= S_CHECK;
              end
`else
              if (wr_addr == len) begin
                state    <= S_RUN;
                running  <= 1'b1;
                in_ready <= 1'b0;
                hold     <= 8'h00;
              end
`endif
            end
          end
`ifdef NANO_LOADER_CKSUM_EN
          S_CHECK: begin
            if (accept) begin
              if (cksum_total == 8'h00) begin
                state    <= S_RUN;
                running  <= 1'b1;
                in_ready <= 1'b0;
                hold     <= 8'h00;
              end else begin
                error <= 1'b1;
                state <= S_IDLE;
              end
            end
          end
`endif
          S_RUN: begin
            // First RUN cycle keeps the core in reset so the last write lands first.
            if (core_reset) begin
              core_reset <= 1'b0;
            end else begin
              if (cycle_count != 16'hFFFF) begin
                cycle_count <= cycle_count + 16'd1;
              end
              pc_prev <= core_pc;
              hold    <= run_len[7:0];
              if (run_len >= HALT_LIM) begin
                state      <= S_HALT;
                running    <= 1'b0;
                halted     <= 1'b1;
                core_reset <= 1'b1;
                in_ready   <= 1'b1;
              end
            end
          end
          default: begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nano_loader.sv
// Self-checking bench for nano_loader: random programs and core PC traces,
// a write/halt scoreboard popped by a monitor, plus directed boundary cases.
module tb_nano_loader;
  localparam int HC = 4;

  logic        clk = 1'b0;
  logic        reset, abort, in_valid;
  logic [7:0]  in_data, core_pc;
  logic        in_ready, prog_we, core_reset, running, halted, error;
  logic [7:0]  prog_addr, prog_data;
  logic [15:0] cycle_count;

  nano_loader #(.HALT_CYCLES(HC)) dut (
    .clk(clk), .reset(reset), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .core_reset(core_reset), .core_pc(core_pc),
    .running(running), .halted(halted), .error(error), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  int         checks = 0;
  int         failures = 0;
  wr_t        wq[$];
  int         cq[$];
  logic [7:0] pc_seq[$];
  int         pc_idx = 0;
  logic       halted_d = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: halt happens on the first sample that completes HC identical
  // consecutive PC values; the run-cycle count is that sample's position.
  function automatic int halt_model();
    int run = 0;
    logic [7:0] prev = 8'h00;
    for (int i = 0; i < 4096; i++) begin
      logic [7:0] v;
      v = (i < pc_seq.size()) ? pc_seq[i] : pc_seq[pc_seq.size() - 1];
      run = (i > 0 && v == prev) ? run + 1 : 1;
      prev = v;
      if (run == HC) return i + 1;
    end
    return -1;
  endfunction

  // Core model: advance through the PC trace on every cycle the core is out of reset.
  always @(negedge clk) begin
    if (!reset && !core_reset) begin
      core_pc = (pc_idx < pc_seq.size()) ? pc_seq[pc_idx] : pc_seq[pc_seq.size() - 1];
      pc_idx++;
    end
  end

  // Monitor: pop expected writes and halt counts as the DUT presents them.
  always @(negedge clk) begin
    wr_t e;
    if (prog_we === 1'b1) begin
      if (wq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write addr=%0h data=%0h none_expected", prog_addr, prog_data);
      end else begin
        e = wq.pop_front();
        chk("write_addr", {24'h0, prog_addr}, {24'h0, e.a});
        chk("write_data", {24'h0, prog_data}, {24'h0, e.d});
      end
    end
    if (halted === 1'b1 && !halted_d) begin
      if (cq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_halt count=%0d none_expected", cycle_count);
      end else begin
        chk("halt_cycle_count", {16'h0, cycle_count}, cq.pop_front());
        chk("halt_core_reset", {31'h0, core_reset}, 32'd1);
        chk("halt_running", {31'h0, running}, 32'd0);
      end
    end
    halted_d = (halted === 1'b1);
  end

  // Offer one byte from a negedge; returns at the negedge after it is accepted.
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout byte=%0h in_ready=%0b required=1", b, in_ready);
    end
    @(negedge clk);
  endtask

  task automatic gap(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Full program: length, data with optional random gaps, checksum when enabled.
  task automatic send_prog(input logic [7:0] prog[$], input bit gaps);
    logic [7:0] s = 8'h00;
    pc_idx = 0;
    cq.push_back(halt_model());
    send(8'(prog.size()));
    chk("len_clears_error", {31'h0, error}, 32'd0);
    chk("len_clears_count", {16'h0, cycle_count}, 32'd0);
    for (int k = 0; k < prog.size(); k++) begin
      wr_t w;
      w.a = 8'(k + 1);
      w.d = prog[k];
      wq.push_back(w);
      s = s + prog[k];
      if (gaps && $urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
      send(prog[k]);
    end
`ifdef NANO_LOADER_CKSUM_EN
    send(8'h00 - s);
`endif
    in_valid = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (halted !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (halted !== 1'b1) begin
      checks++; failures++;
      $display("FAIL %s halt_timeout halted=%0b required=1", name, halted);
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prog[$];
    reset = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00; core_pc = 8'h00;
    pc_seq = {8'h00};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'd0);
    chk("rst_prog_we", {31'h0, prog_we}, 32'd0);
    chk("rst_prog_addr", {24'h0, prog_addr}, 32'd0);
    chk("rst_prog_data", {24'h0, prog_data}, 32'd0);
    chk("rst_core_reset", {31'h0, core_reset}, 32'd1);
    chk("rst_running", {31'h0, running}, 32'd0);
    chk("rst_halted", {31'h0, halted}, 32'd0);
    chk("rst_error", {31'h0, error}, 32'd0);
    chk("rst_cycle_count", {16'h0, cycle_count}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'h0, in_ready}, 32'd1);

    // Directed: 03 81 82 C3 back-to-back, core stuck at 05.
    pc_seq = {8'h05};
    prog = {8'h81, 8'h82, 8'hC3};
    send_prog(prog, 1'b0);
    chk("enter_running", {31'h0, running}, 32'd1);
    chk("enter_core_reset_hi", {31'h0, core_reset}, 32'd1);
    chk("enter_in_ready", {31'h0, in_ready}, 32'd0);
    @(negedge clk);
    chk("core_reset_released", {31'h0, core_reset}, 32'd0);
    wait_halt("stuck05");
    repeat (3) @(negedge clk);
    chk("count_frozen", {16'h0, cycle_count}, 32'd4);
    chk("halt_in_ready", {31'h0, in_ready}, 32'd1);

    // Zero length from HALT: error, IDLE, no writes.
    send(8'h00);
    in_valid = 1'b0;
    chk("zero_len_error", {31'h0, error}, 32'd1);
    chk("zero_len_halted", {31'h0, halted}, 32'd0);
    chk("zero_len_running", {31'h0, running}, 32'd0);
    chk("zero_len_core_reset", {31'h0, core_reset}, 32'd1);
    gap(3);

    // Random programs with random PC traces (includes wrap FF->00 and near-halts).
    for (int it = 0; it < 8; it++) begin
      int L;
      L = (it == 0) ? 255 : $urandom_range(1, 24);
      prog = {};
      for (int k = 0; k < L; k++) prog.push_back(8'($urandom));
      pc_seq = {};
      for (int k = 0; k < $urandom_range(0, 12); k++) begin
        pc_seq.push_back(8'($urandom_range(0, 2) == 0 ? 8'hFF : $urandom_range(0, 2)));
      end
      if (it == 1) pc_seq = {8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h01};
      pc_seq.push_back(8'($urandom));
      send_prog(prog, 1'b1);
      wait_halt("random_run");
      gap($urandom_range(0, 3));
    end

    // Abort mid-LOAD after 2 of 5 bytes, with a same-cycle byte offered.
    begin
      wr_t w;
      send(8'h05);
      w.a = 8'h01; w.d = 8'h11; wq.push_back(w);
      send(8'h11);
      w.a = 8'h02; w.d = 8'h22; wq.push_back(w);
      send(8'h22);
      abort = 1'b1; in_valid = 1'b1; in_data = 8'h77;
      @(negedge clk);
      abort = 1'b0; in_valid = 1'b0;
      chk("abort_in_ready", {31'h0, in_ready}, 32'd1);
      chk("abort_core_reset", {31'h0, core_reset}, 32'd1);
      chk("abort_running", {31'h0, running}, 32'd0);
      chk("abort_error_kept", {31'h0, error}, 32'd0);
      chk("abort_count_kept", {16'h0, cycle_count}, 32'd0);
      gap(3);
      // If 0x77 had been taken as a length, this 00 would be written, not flagged.
      send(8'h00);
      in_valid = 1'b0;
      chk("abort_then_zero_error", {31'h0, error}, 32'd1);
      gap(2);
    end

`ifdef NANO_LOADER_CKSUM_EN
    begin
      wr_t w;
      pc_seq = {8'h09};
      pc_idx = 0;
      cq.push_back(halt_model());
      send(8'h02);
      w.a = 8'h01; w.d = 8'h10; wq.push_back(w); send(8'h10);
      w.a = 8'h02; w.d = 8'h20; wq.push_back(w); send(8'h20);
      send(8'hD0);
      in_valid = 1'b0;
      chk("cksum_ok_running", {31'h0, running}, 32'd1);
      wait_halt("cksum_ok");
      send(8'h02);
      w.a = 8'h01; w.d = 8'h10; wq.push_back(w); send(8'h10);
      w.a = 8'h02; w.d = 8'h20; wq.push_back(w); send(8'h20);
      send(8'hD1);
      in_valid = 1'b0;
      chk("cksum_bad_error", {31'h0, error}, 32'd1);
      chk("cksum_bad_running", {31'h0, running}, 32'd0);
      chk("cksum_bad_core_reset", {31'h0, core_reset}, 32'd1);
      chk("cksum_bad_in_ready", {31'h0, in_ready}, 32'd1);
      gap(3);
      chk("cksum_bad_stays_reset", {31'h0, core_reset}, 32'd1);
    end
`endif

    gap(5);
    chk("writes_drained", wq.size(), 32'd0);
    chk("halts_drained", cq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
